// File: rtl/mont_pkg.sv
`default_nettype none
// mont_pkg: shared widths, word types and FSM state encoding for the CIOS Montgomery multiplier.
package mont_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_WORDS  = 32;

  typedef logic [DEF_DATA_WIDTH-1:0]   word_t;
  typedef logic [2*DEF_DATA_WIDTH-1:0] dword_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL     = 3'd1,
    ST_MUL_TOP = 3'd2,
    ST_QUOT    = 3'd3,
    ST_RED     = 3'd4,
    ST_RED_TOP = 3'd5,
    ST_SUB     = 3'd6,
    ST_FINAL   = 3'd7
  } state_t;

endpackage : mont_pkg
`default_nettype wire

// File: rtl/mont_mac.sv
`default_nettype none
// mont_mac: single shared word multiply-accumulate, prod = x*y + c + d (never overflows 2W bits).
module mont_mac
  import mont_pkg::*;
#(
  parameter int W = DEF_DATA_WIDTH
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic [W-1:0]   c,
  input  logic [W-1:0]   d,
  output logic [2*W-1:0] prod
);

  always_comb begin
    prod = {{W{1'b0}}, x} * {{W{1'b0}}, y} + {{W{1'b0}}, c} + {{W{1'b0}}, d};
  end

endmodule : mont_mac
`default_nettype wire

// File: rtl/mont_mult_cios.sv
`default_nettype none
// mont_mult_cios: word-serial CIOS Montgomery multiplier, result = a*b*R^-1 mod n.
// Build option MONT_LAZY_REDUCTION_EN drops the final subtraction (result < 2n, shorter latency).
module mont_mult_cios
  import mont_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WORDS  = DEF_NUM_WORDS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0]  a,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0]  b,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0]  n,
  input  logic [DATA_WIDTH-1:0]            n0prime,
  output logic [DATA_WIDTH*NUM_WORDS-1:0]  result,
  output logic                             done,
  output logic                             busy
);

  localparam int W   = DATA_WIDTH;
  localparam int S   = NUM_WORDS;
  localparam int OPW = W * S;
  localparam int IW  = $clog2(S + 2);
  localparam int WIX = $clog2(S);

  localparam logic [IW-1:0]  J_LAST = IW'(S - 1);
  localparam logic [IW-1:0]  J_TOP  = IW'(S);
  localparam logic [IW-1:0]  J_TOP1 = IW'(S + 1);
  localparam logic [WIX-1:0] I_LAST = WIX'(S - 1);

  state_t state, state_nxt;

  logic [OPW-1:0] a_r, b_r, n_r;
  logic [W-1:0]   n0p_r, m_r, carry_r;
  logic [WIX-1:0] i_r;
  logic [IW-1:0]  j_r;
  logic [W-1:0]   t_r [S+2];

  logic [W-1:0]   a_w [S];
  logic [W-1:0]   b_w [S];
  logic [W-1:0]   n_w [S];
  logic [WIX-1:0] jw;
  logic [IW-1:0]  j_prev;
  logic           accept;

  logic [W-1:0]   mac_x, mac_y, mac_c, mac_d;
  logic [2*W-1:0] mac_p;
  logic [W-1:0]   mac_lo, mac_hi;

  genvar g;
  generate
    for (g = 0; g < S; g++) begin : g_unpack
      assign a_w[g] = a_r[g*W +: W];
      assign b_w[g] = b_r[g*W +: W];
      assign n_w[g] = n_r[g*W +: W];
    end
  endgenerate

  assign jw     = j_r[WIX-1:0];
  assign j_prev = j_r - IW'(1);
  // done is held off as an accept condition so a start can never overlap the done pulse
  assign accept = (state == ST_IDLE) && start && !done;
  assign mac_lo = mac_p[W-1:0];
  assign mac_hi = mac_p[2*W-1:W];

  mont_mac #(.W(W)) u_mac (
    .x    (mac_x),
    .y    (mac_y),
    .c    (mac_c),
    .d    (mac_d),
    .prod (mac_p)
  );

`ifndef MONT_LAZY_REDUCTION_EN
  logic [W-1:0] d_r [S];
  logic         borrow_r;
  logic [W-1:0] n_sub;
  logic [W:0]   sub_w;

  // word S of the modulus is an implicit zero; the borrow out of that word decides t >= n
  assign n_sub = (j_r == J_TOP) ? '0 : n_w[jw];
  assign sub_w = {1'b0, t_r[j_r]} - {1'b0, n_sub} - {{W{1'b0}}, borrow_r};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mac_x     = '0;
    mac_y     = '0;
    mac_c     = '0;
    mac_d     = '0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_MUL;
      end
      ST_MUL: begin
        mac_x = a_w[jw];
        mac_y = b_w[i_r];
        mac_c = t_r[j_r];
        mac_d = carry_r;
        if (j_r == J_LAST) state_nxt = ST_MUL_TOP;
      end
      ST_MUL_TOP: begin
        mac_c     = t_r[J_TOP];
        mac_d     = carry_r;
        state_nxt = ST_QUOT;
      end
      ST_QUOT: begin
        mac_x     = t_r[0];
        mac_y     = n0p_r;
        state_nxt = ST_RED;
      end
      ST_RED: begin
        mac_x = m_r;
        mac_y = n_w[jw];
        mac_c = t_r[j_r];
        mac_d = carry_r;
        if (j_r == J_LAST) state_nxt = ST_RED_TOP;
      end
      ST_RED_TOP: begin
        mac_c = t_r[J_TOP];
        mac_d = carry_r;
        if (i_r == I_LAST) begin
`ifdef MONT_LAZY_REDUCTION_EN
          state_nxt = ST_FINAL;
`else
          state_nxt = ST_SUB;
`endif
        end else begin
          state_nxt = ST_MUL;
        end
      end
`ifndef MONT_LAZY_REDUCTION_EN
      ST_SUB: begin
        if (j_r == J_TOP) state_nxt = ST_FINAL;
      end
`endif
      ST_FINAL: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      n_r     <= '0;
      n0p_r   <= '0;
      m_r     <= '0;
      carry_r <= '0;
      i_r     <= '0;
      j_r     <= '0;
      result  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      for (int k = 0; k < S + 2; k++) t_r[k] <= '0;
`ifndef MONT_LAZY_REDUCTION_EN
      borrow_r <= 1'b0;
      for (int k = 0; k < S; k++) d_r[k] <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_r     <= a;
            b_r     <= b;
            n_r     <= n;
            n0p_r   <= n0prime;
            i_r     <= '0;
            j_r     <= '0;
            carry_r <= '0;
            busy    <= 1'b1;
            for (int k = 0; k < S + 2; k++) t_r[k] <= '0;
          end
        end
        ST_MUL: begin
          t_r[j_r] <= mac_lo;
          carry_r  <= mac_hi;
          j_r      <= (j_r == J_LAST) ? '0 : j_r + IW'(1);
        end
        ST_MUL_TOP: begin
          t_r[J_TOP]  <= mac_lo;
          t_r[J_TOP1] <= mac_hi;
        end
        ST_QUOT: begin
          m_r     <= mac_lo;
          carry_r <= '0;
          j_r     <= '0;
        end
        ST_RED: begin
          // the j=0 sum is zero by choice of m, so the words shift down by one
          if (j_r != '0) t_r[j_prev] <= mac_lo;
          carry_r <= mac_hi;
          j_r     <= (j_r == J_LAST) ? '0 : j_r + IW'(1);
        end
        ST_RED_TOP: begin
          t_r[J_LAST] <= mac_lo;
          t_r[J_TOP]  <= t_r[J_TOP1] + mac_hi;
          t_r[J_TOP1] <= '0;
          carry_r     <= '0;
          j_r         <= '0;
`ifndef MONT_LAZY_REDUCTION_EN
          borrow_r    <= 1'b0;
`endif
          if (i_r != I_LAST) i_r <= i_r + WIX'(1);
        end
`ifndef MONT_LAZY_REDUCTION_EN
        ST_SUB: begin
          if (j_r != J_TOP) d_r[jw] <= sub_w[W-1:0];
          borrow_r <= sub_w[W];
          j_r      <= j_r + IW'(1);
        end
`endif
        ST_FINAL: begin
          for (int k = 0; k < S; k++) begin
`ifdef MONT_LAZY_REDUCTION_EN
            result[k*W +: W] <= t_r[k];
`else
            result[k*W +: W] <= borrow_r ? t_r[k] : d_r[k];
`endif
          end
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule : mont_mult_cios
`default_nettype wire

// File: tb/tb_mont_mult_cios.sv
`default_nettype none
// tb_mont_mult_cios: directed and random checks of the CIOS multiplier against a whole-number REDC model.
module tb_mont_mult_cios;

  localparam int W   = 32;
  localparam int S   = 32;
  localparam int OPW = W * S;
`ifdef MONT_LAZY_REDUCTION_EN
  localparam int LAT = S * (2 * S + 3) + 1;
`else
  localparam int LAT = S * (2 * S + 3) + S + 2;
`endif
  localparam int XW = 2 * OPW + 2;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [OPW-1:0] a, b, n, result;
  logic [W-1:0]   n0prime;
  logic           done, busy;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mont_mult_cios #(.DATA_WIDTH(W), .NUM_WORDS(S)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .n       (n),
    .n0prime (n0prime),
    .result  (result),
    .done    (done),
    .busy    (busy)
  );

  function automatic logic [OPW-1:0] rand_vec();
    logic [OPW-1:0] v;
    for (int k = 0; k < S; k++) v[k*W +: W] = $urandom;
    return v;
  endfunction

  // -n^-1 mod R by Newton iteration; precision doubles each step from 3 bits
  function automatic logic [OPW-1:0] neg_inv(input logic [OPW-1:0] fn);
    logic [OPW-1:0] x, two;
    two = 2;
    x   = fn;
    for (int k = 0; k < 10; k++) x = x * (two - fn * x);
    return '0 - x;
  endfunction

  function automatic logic [XW-1:0] zx(input logic [OPW-1:0] v);
    return {{(XW-OPW){1'b0}}, v};
  endfunction

  // REDC on whole numbers: u = (ab + q*n)/R with q = -ab*n^-1 mod R
  function automatic logic [OPW-1:0] mont_ref(input logic [OPW-1:0] fa, fb, fn);
    logic [XW-1:0]  ab, tmp, u;
    logic [OPW-1:0] q;
    ab  = zx(fa) * zx(fb);
    tmp = zx(ab[OPW-1:0]) * zx(neg_inv(fn));
    q   = tmp[OPW-1:0];
    u   = (ab + zx(q) * zx(fn)) >> OPW;
`ifndef MONT_LAZY_REDUCTION_EN
    if (u >= zx(fn)) u = u - zx(fn);
`endif
    return u[OPW-1:0];
  endfunction

  function automatic logic [W-1:0] n0p_of(input logic [OPW-1:0] fn);
    logic [OPW-1:0] v;
    v = neg_inv(fn);
    return v[W-1:0];
  endfunction

  function automatic logic [OPW-1:0] rand_mod();
    logic [OPW-1:0] v;
    v = rand_vec();
    v[0] = 1'b1;
    v[OPW-1:OPW-2] = 2'b00;
    v[OPW-3] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [OPW-1:0] obs, input logic [OPW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed(lo128)=%h required(lo128)=%h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic run_mult(input logic [OPW-1:0] ta, tb, tn, input logic [W-1:0] np,
                          input bit disturb, output logic [OPW-1:0] res, output int lat,
                          output logic busy1, output logic done_after);
    a = ta; b = tb; n = tn; n0prime = np; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    busy1 = 1'b0;
    while (done !== 1'b1 && lat < LAT + 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) busy1 = busy;
      start = 1'b0;
      if (disturb && lat == 2) begin a = rand_vec(); b = rand_vec(); end
      if (disturb && lat == 100) begin start = 1'b1; a = ~ta; n0prime = ~np; end
    end
    res = result;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic mult_and_check(input string tag, input logic [OPW-1:0] ta, tb, tn,
                                input logic [W-1:0] np, input logic [OPW-1:0] exp, input bit disturb);
    logic [OPW-1:0] res;
    int             lat;
    logic           busy1, done_after;
    run_mult(ta, tb, tn, np, disturb, res, lat, busy1, done_after);
    check({tag, "_result"}, res, exp);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_busy"}, busy1, 1);
    check({tag, "_single_done"}, done_after, 0);
  endtask

  initial begin
    logic [OPW-1:0] ra, rb, rn, all1, v13, res;
    int             lat;
    logic           busy1, done_after;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; n = '0; n0prime = '0;
    all1 = '1;
    v13  = 13;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

`ifndef MONT_LAZY_REDUCTION_EN
    mult_and_check("all1_3x5", 3, 5, all1, 32'h0000_0001, 15, 1'b0);
    mult_and_check("all1_nm1sq", all1 - 1, all1 - 1, all1, 32'h0000_0001, 1, 1'b0);
    mult_and_check("n13_1x1", 1, 1, v13, 32'h3B13_B13B, 9, 1'b0);
    mult_and_check("n13_3x7", 3, 7, v13, 32'h3B13_B13B, 7, 1'b0);
`else
    run_mult(1, 1, v13, 32'h3B13_B13B, 1'b0, res, lat, busy1, done_after);
    check("lazy_n13_range", (res == 9 || res == 22), 1);
    check("lazy_n13_model", res, mont_ref(1, 1, v13));
    check("lazy_n13_latency", lat, LAT);
    check("lazy_n13_single_done", done_after, 0);
    mult_and_check("lazy_n13_3x7", 3, 7, v13, 32'h3B13_B13B, mont_ref(3, 7, v13), 1'b0);
`endif

    rn = rand_mod(); ra = rand_vec() % rn; rb = rand_vec() % rn;
    mult_and_check("disturbed", ra, rb, rn, n0p_of(rn), mont_ref(ra, rb, rn), 1'b1);

    // asynchronous abort part-way through a multiply
    rn = rand_mod(); ra = rand_vec() % rn; rb = rand_vec() % rn;
    a = ra; b = rb; n = rn; n0prime = n0p_of(rn); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mult_and_check("after_abort", ra, rb, rn, n0p_of(rn), mont_ref(ra, rb, rn), 1'b0);

    for (int r = 0; r < 3; r++) begin
      rn = rand_mod(); ra = rand_vec() % rn; rb = rand_vec() % rn;
      mult_and_check("random", ra, rb, rn, n0p_of(rn), mont_ref(ra, rb, rn), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_mont_mult_cios
`default_nettype wire
